// File: rtl/receiver_block.sv
// rtl/receiver_block.sv - read-response checker: command queue, masked pattern compare, first-error capture
module receiver_block #(
    parameter int AMM_DATA_W     = 128,
    parameter int AMM_ADDR_W     = 12,
    parameter int AMM_BURST_W    = 11,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int ERR_CNT_W      = 32,
    parameter int BYTE_PER_WORD  = AMM_DATA_W / 8,
    parameter int BYTE_ADDR_W    = $clog2(BYTE_PER_WORD)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_start_i,
    input  logic                   rnd_en_i,
    input  logic [7:0]             pattern_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [AMM_ADDR_W-1:0]  cmd_addr_i,
    input  logic [AMM_BURST_W-1:0] cmd_burst_i,
    input  logic [BYTE_ADDR_W-1:0] cmd_start_off_i,
    input  logic [BYTE_ADDR_W:0]   cmd_end_off_i,
    input  logic                   readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]  readdata_i,
    output logic                   busy_o,
    output logic                   burst_done_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o,
    output logic                   err_valid_o,
    output logic [AMM_ADDR_W-1:0]  err_addr_o,
    output logic [7:0]             err_data_o,
    output logic [7:0]             err_exp_o,
    output logic                   spurious_o
);
    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);

    logic [AMM_ADDR_W-1:0]  fifo_addr_q  [CMD_FIFO_DEPTH];
    logic [AMM_BURST_W-1:0] fifo_burst_q [CMD_FIFO_DEPTH];
    logic [BYTE_ADDR_W-1:0] fifo_soff_q  [CMD_FIFO_DEPTH];
    logic [BYTE_ADDR_W:0]   fifo_eoff_q  [CMD_FIFO_DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [AMM_BURST_W-1:0] word_idx_q, word_idx_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic                   spurious_q, spurious_d;

    logic                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [AMM_DATA_W-1:0]  s1_data_q, s1_data_d;
    logic [BYTE_PER_WORD-1:0] s1_mask_q, s1_mask_d;
    logic [7:0]             s1_exp_q, s1_exp_d;
    logic [AMM_ADDR_W-1:0]  s1_addr_q, s1_addr_d;

    logic                   burst_done_q, burst_done_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   err_valid_q, err_valid_d;
    logic [AMM_ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [7:0]             err_data_q, err_data_d, err_exp_q, err_exp_d;

    logic                   fifo_empty, fifo_full, push, accept, pop;
    logic                   first_word, last_word;
    logic [AMM_BURST_W-1:0] last_idx;
    logic [BYTE_PER_WORD-1:0] lane_mask, mism;
    logic [BYTE_ADDR_W-1:0] low_lane;
    logic [AMM_ADDR_W-1:0]  word_addr;

    // Ready comes from registered occupancy, so a push while full is dropped even if the head pops.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(CMD_FIFO_DEPTH));
    assign push       = cmd_valid_i && !fifo_full && !test_start_i;
    assign accept     = readdatavalid_i && !fifo_empty && !test_start_i;
    assign last_idx   = (fifo_burst_q[rd_ptr_q] == '0) ? '0 : fifo_burst_q[rd_ptr_q] - 1'b1;
    assign first_word = (word_idx_q == '0);
    assign last_word  = (word_idx_q == last_idx);
    assign pop        = accept && last_word;
    assign word_addr  = fifo_addr_q[rd_ptr_q]
                      + AMM_ADDR_W'({word_idx_q, {BYTE_ADDR_W{1'b0}}});

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= cmd_addr_i;
            fifo_burst_q[wr_ptr_q] <= cmd_burst_i;
            fifo_soff_q[wr_ptr_q]  <= cmd_start_off_i;
            fifo_eoff_q[wr_ptr_q]  <= cmd_end_off_i;
        end
    end

    always_comb begin
        lane_mask = '1;
        for (int i = 0; i < BYTE_PER_WORD; i++) begin
            if (first_word && (BYTE_ADDR_W'(i) < fifo_soff_q[rd_ptr_q]))
                lane_mask[i] = 1'b0;
            if (last_word && (fifo_eoff_q[rd_ptr_q] != '0)
                && ((BYTE_ADDR_W+1)'(i) >= fifo_eoff_q[rd_ptr_q]))
                lane_mask[i] = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        lfsr_d     = lfsr_q;
        spurious_d = spurious_q;
        if (test_start_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            word_idx_d = '0;
            lfsr_d     = 8'hFF;
            spurious_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                word_idx_d = '0;
            end else if (accept) begin
                word_idx_d = word_idx_q + 1'b1;
            end
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (accept && rnd_en_i) lfsr_d = {lfsr_q[6:0], lfsr_q[6] ^ lfsr_q[1] ^ lfsr_q[0]};
            if (readdatavalid_i && fifo_empty) spurious_d = 1'b1;
        end
    end

    always_comb begin
        mism     = '0;
        low_lane = '0;
        for (int i = 0; i < BYTE_PER_WORD; i++)
            mism[i] = s1_mask_q[i] && (s1_data_q[8*i +: 8] != s1_exp_q);
        for (int i = BYTE_PER_WORD - 1; i >= 0; i--)
            if (mism[i]) low_lane = BYTE_ADDR_W'(i);
    end

    always_comb begin
        s1_valid_d   = accept;
        s1_last_d    = s1_last_q;
        s1_data_d    = s1_data_q;
        s1_mask_d    = s1_mask_q;
        s1_exp_d     = s1_exp_q;
        s1_addr_d    = s1_addr_q;
        burst_done_d = s1_valid_q && s1_last_q && !test_start_i;
        err_cnt_d    = err_cnt_q;
        err_valid_d  = err_valid_q;
        err_addr_d   = err_addr_q;
        err_data_d   = err_data_q;
        err_exp_d    = err_exp_q;
        if (accept) begin
            s1_last_d = last_word;
            s1_data_d = readdata_i;
            s1_mask_d = lane_mask;
            s1_exp_d  = rnd_en_i ? lfsr_q : pattern_i;
            s1_addr_d = word_addr;
        end
        if (test_start_i) begin
            err_cnt_d   = '0;
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_data_d  = '0;
            err_exp_d   = '0;
        end else if (s1_valid_q && (mism != '0)) begin
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
            if (!err_valid_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = s1_addr_q + AMM_ADDR_W'(low_lane);
                err_data_d  = s1_data_q[{low_lane, 3'b000} +: 8];
                err_exp_d   = s1_exp_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            word_idx_q   <= '0;
            lfsr_q       <= 8'hFF;
            spurious_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_data_q    <= '0;
            s1_mask_q    <= '0;
            s1_exp_q     <= '0;
            s1_addr_q    <= '0;
            burst_done_q <= 1'b0;
            err_cnt_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_data_q   <= '0;
            err_exp_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            lfsr_q       <= lfsr_d;
            spurious_q   <= spurious_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_data_q    <= s1_data_d;
            s1_mask_q    <= s1_mask_d;
            s1_exp_q     <= s1_exp_d;
            s1_addr_q    <= s1_addr_d;
            burst_done_q <= burst_done_d;
            err_cnt_q    <= err_cnt_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
            err_data_q   <= err_data_d;
            err_exp_q    <= err_exp_d;
        end
    end

    assign cmd_ready_o  = !fifo_full;
    assign busy_o       = !fifo_empty || s1_valid_q;
    assign burst_done_o = burst_done_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_valid_o  = err_valid_q;
    assign err_addr_o   = err_addr_q;
    assign err_data_o   = err_data_q;
    assign err_exp_o    = err_exp_q;
    assign spurious_o   = spurious_q;
endmodule

// File: tb/tb_receiver_block.sv
// tb/tb_receiver_block.sv - scoreboard bench for receiver_block with randomized bursts and a queue-based model
module tb_receiver_block;
    localparam int DW = 128;
    localparam int AW = 12;
    localparam int BW = 11;
    localparam int NB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, test_start, rnd_en, cmd_valid, rdv;
    logic [7:0]    pattern;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_burst;
    logic [3:0]    cmd_soff;
    logic [4:0]    cmd_eoff;
    logic [DW-1:0] readdata;

    logic          cmd_ready_o, busy_o, burst_done_o, err_valid_o, spurious_o;
    logic [31:0]   err_cnt_o;
    logic [AW-1:0] err_addr_o;
    logic [7:0]    err_data_o, err_exp_o;

    logic          s_cmd_ready, s_busy, s_burst_done, s_err_valid, s_spurious;
    logic [1:0]    s_err_cnt;
    logic [AW-1:0] s_err_addr;
    logic [7:0]    s_err_data, s_err_exp;

    receiver_block dut (
        .clk_i(clk), .rst_i(rst), .test_start_i(test_start), .rnd_en_i(rnd_en),
        .pattern_i(pattern), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr), .cmd_burst_i(cmd_burst), .cmd_start_off_i(cmd_soff),
        .cmd_end_off_i(cmd_eoff), .readdatavalid_i(rdv), .readdata_i(readdata),
        .busy_o(busy_o), .burst_done_o(burst_done_o), .err_cnt_o(err_cnt_o),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_data_o(err_data_o),
        .err_exp_o(err_exp_o), .spurious_o(spurious_o)
    );

    receiver_block #(.ERR_CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .test_start_i(test_start), .rnd_en_i(rnd_en),
        .pattern_i(pattern), .cmd_valid_i(cmd_valid), .cmd_ready_o(s_cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_burst_i(cmd_burst), .cmd_start_off_i(cmd_soff),
        .cmd_end_off_i(cmd_eoff), .readdatavalid_i(rdv), .readdata_i(readdata),
        .busy_o(s_busy), .burst_done_o(s_burst_done), .err_cnt_o(s_err_cnt),
        .err_valid_o(s_err_valid), .err_addr_o(s_err_addr), .err_data_o(s_err_data),
        .err_exp_o(s_err_exp), .spurious_o(s_spurious)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] burst;
        logic [3:0]    so;
        logic [4:0]    eo;
    } cmd_t;

    typedef struct {
        int            cnt;
        bit            ev;
        logic [AW-1:0] addr;
        logic [7:0]    d;
        logic [7:0]    e;
    } res_t;

    cmd_t mq[$];
    res_t sb[$];

    int            m_cnt;
    bit            m_ev;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_d, m_e, m_lfsr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[6] ^ l[1] ^ l[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0; m_ev = 0; m_addr = '0; m_d = '0; m_e = '0; m_lfsr = 8'hFF;
        mq.delete();
        sb.delete();
    endtask

    task automatic do_start(input bit rnd, input logic [7:0] pat);
        rnd_en = rnd;
        pattern = pat;
        test_start = 1'b1;
        tick();
        test_start = 1'b0;
        model_clear();
    endtask

    task automatic push_cmd(input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [3:0] s, input logic [4:0] e);
        cmd_t c;
        bit   acc;
        acc = (mq.size() < 4);
        check("cmd_ready", cmd_ready_o, acc);
        cmd_addr = a; cmd_burst = b; cmd_soff = s; cmd_eoff = e;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        c.addr = a; c.burst = b; c.so = s; c.eo = e;
        if (acc) mq.push_back(c);
    endtask

    // Builds one response word from the expected pattern, corrupting the lanes in bad by xor x.
    task automatic send_word(input cmd_t c, input int w, input logic [15:0] bad, input logic [7:0] x);
        int            nw;
        int            low;
        logic [7:0]    eb, b;
        logic [DW-1:0] data;
        logic [AW-1:0] wa;
        bit            cov;
        nw  = (c.burst == 0) ? 1 : int'(c.burst);
        eb  = rnd_en ? m_lfsr : pattern;
        wa  = c.addr + AW'(w * NB);
        low = -1;
        for (int i = 0; i < NB; i++) begin
            b = bad[i] ? (eb ^ x) : eb;
            data[8*i +: 8] = b;
            cov = (w != 0 || i >= int'(c.so)) && (w != nw - 1 || c.eo == 0 || i < int'(c.eo));
            if (cov && b != eb && low < 0) low = i;
        end
        if (low >= 0) begin
            m_cnt++;
            if (!m_ev) begin
                m_ev = 1; m_addr = wa + AW'(low); m_d = eb ^ x; m_e = eb;
            end
        end
        if (rnd_en) m_lfsr = lfsr_next(m_lfsr);
        readdata = data;
        rdv = 1'b1;
        tick();
        rdv = 1'b0;
        if (w == nw - 1) sb.push_back('{m_cnt, m_ev, m_addr, m_d, m_e});
    endtask

    task automatic stream_all(input bit errs, input bit gaps);
        cmd_t c;
        int   nw;
        while (mq.size() > 0) begin
            c  = mq.pop_front();
            nw = (c.burst == 0) ? 1 : int'(c.burst);
            for (int w = 0; w < nw; w++) begin
                send_word(c, w, (errs && $urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0,
                          8'($urandom_range(1, 255)));
                if (gaps && $urandom_range(0, 3) == 0) tick();
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy_o || sb.size() > 0) && k < 40) begin
            tick();
            k++;
        end
        check("drain_busy", busy_o, 0);
        check("drain_sb_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        res_t r;
        if (!rst && burst_done_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL burst_done: pulse with no burst expected");
            end else begin
                r = sb.pop_front();
                check("sb_err_cnt", err_cnt_o, r.cnt);
                check("sb_err_valid", err_valid_o, r.ev);
                check("sb_err_addr", err_addr_o, r.addr);
                check("sb_err_data", err_data_o, r.d);
                check("sb_err_exp", err_exp_o, r.e);
                check("sb_sat_cnt", s_err_cnt, (r.cnt > 3) ? 3 : r.cnt);
                check("sb_sat_done", s_burst_done, 1);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        cmd_t c;
        int   n;
        logic [AW-1:0] a;
        rst = 1'b1; test_start = 1'b0; rnd_en = 1'b0; pattern = '0; cmd_valid = 1'b0;
        rdv = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_soff = '0; cmd_eoff = '0; readdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_burst_done", burst_done_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_err_valid", err_valid_o, 0);
        check("rst_err_addr", err_addr_o, 0);
        check("rst_err_data", err_data_o, 0);
        check("rst_err_exp", err_exp_o, 0);
        check("rst_spurious", spurious_o, 0);
        rst = 1'b0;
        tick();
        model_clear();

        // Four matching words, then burst_done two cycles after the last one.
        do_start(0, 8'hA5);
        push_cmd(12'h100, 4, 0, 0);
        c = mq.pop_front();
        for (int w = 0; w < 4; w++) send_word(c, w, 16'h0, 8'h00);
        check("t1_done_early", burst_done_o, 0);
        tick();
        check("t1_done_pulse", burst_done_o, 1);
        check("t1_busy_low", busy_o, 0);
        check("t1_err_cnt", err_cnt_o, 0);
        tick();

        push_cmd(12'h100, 4, 0, 0);
        c = mq.pop_front();
        for (int w = 0; w < 4; w++) send_word(c, w, (w == 2) ? 16'h0008 : 16'h0, 8'hA5);
        drain();
        check("t2_err_cnt", err_cnt_o, 1);
        check("t2_err_valid", err_valid_o, 1);
        check("t2_err_addr", err_addr_o, 12'h123);
        check("t2_err_data", err_data_o, 8'h00);
        check("t2_err_exp", err_exp_o, 8'hA5);

        // Lane masking on a single-word burst.
        do_start(0, 8'h3C);
        push_cmd(12'h240, 1, 4, 12);
        c = mq.pop_front();
        send_word(c, 0, 16'hF00F, 8'($urandom_range(1, 255)));
        drain();
        check("t3_masked_cnt", err_cnt_o, 0);
        push_cmd(12'h240, 1, 4, 12);
        c = mq.pop_front();
        send_word(c, 0, 16'h0010, 8'($urandom_range(1, 255)));
        drain();
        check("t3_lane4_cnt", err_cnt_o, 1);
        check("t3_lane4_addr", err_addr_o, 12'h244);

        do_start(1, 8'h96);
        push_cmd(12'h000, 3, 0, 0);
        stream_all(0, 0);
        drain();
        check("t4_lfsr_cnt", err_cnt_o, 0);

        // Full FIFO, ready after first pop, then spurious responses.
        do_start(0, 8'h5A);
        for (int k = 0; k < 5; k++) push_cmd(AW'(12'h400 + k * 32), 2, 0, 0);
        c = mq.pop_front();
        for (int w = 0; w < 2; w++) send_word(c, w, 16'h0, 8'h00);
        check("t5_ready_after_pop", cmd_ready_o, 1);
        stream_all(1, 0);
        drain();
        check("t5_spur_before", spurious_o, 0);
        readdata = {DW{1'b1}};
        rdv = 1'b1;
        tick();
        rdv = 1'b0;
        tick();
        tick();
        check("t5_spurious", spurious_o, 1);
        check("t5_spur_cnt", err_cnt_o, m_cnt);

        do_start(0, 8'h77);
        cmd_addr = 12'h600; cmd_burst = 1; cmd_soff = 0; cmd_eoff = 0;
        cmd_valid = 1'b1;
        readdata = '0;
        rdv = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rdv = 1'b0;
        c.addr = 12'h600; c.burst = 1; c.so = 0; c.eo = 0;
        mq.push_back(c);
        check("t5_same_cycle_spur", spurious_o, 1);
        check("t5_same_cycle_busy", busy_o, 1);
        stream_all(0, 0);
        drain();
        check("t5_same_cycle_cnt", err_cnt_o, 0);

        // Saturation on the narrow counter, then test_start mid-burst.
        do_start(0, 8'hC3);
        push_cmd(12'h800, 5, 0, 0);
        c = mq.pop_front();
        for (int w = 0; w < 5; w++) send_word(c, w, 16'hFFFF, 8'($urandom_range(1, 255)));
        drain();
        check("t6_cnt", err_cnt_o, 5);
        check("t6_sat_cnt", s_err_cnt, 3);
        push_cmd(12'h900, 4, 0, 0);
        c = mq.pop_front();
        for (int w = 0; w < 2; w++) send_word(c, w, 16'hFFFF, 8'h11);
        do_start(0, 8'hC3);
        check("t6_abort_cnt", err_cnt_o, 0);
        check("t6_abort_sat", s_err_cnt, 0);
        check("t6_abort_valid", err_valid_o, 0);
        check("t6_abort_addr", err_addr_o, 0);
        check("t6_abort_spur", spurious_o, 0);
        check("t6_abort_busy", busy_o, 0);
        check("t6_abort_ready", cmd_ready_o, 1);
        tick();
        tick();
        check("t6_abort_no_done", burst_done_o, 0);

        for (int r = 0; r < 25; r++) begin
            do_start(1'($urandom_range(0, 1)), 8'($urandom));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                a = ($urandom_range(0, 3) == 0) ? 12'hFE0 : {8'($urandom), 4'h0};
                push_cmd(a, BW'($urandom_range(0, 6)), 4'($urandom), 5'($urandom_range(0, 16)));
            end
            stream_all(1, 1);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
